conv_encoder: RTL and testbench

//  Rate-1/2 feed-forward (non-recursive) convolutional encoder. Feeds the Viterbi decoder in the System datapath.
//  One input bit per clock produces one registered 2-bit parity pair.

---
 rtl/conv_enc_pkg.sv | 22 ++
 rtl/conv_enc_shreg.sv | 30 +++
 rtl/conv_encoder.sv | 59 +++++
 tb/tb_conv_encoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared constants and helpers for the rate-1/2 convolutional encoder.
package conv_enc_pkg;

    // Widest window the encoder supports; parity() works on zero-extended operands.
    localparam int unsigned MAX_K = 9;

    // V1: K=3, generators 7/5 octal.
    localparam int unsigned V1_K  = 3;
    localparam logic [2:0]  V1_G0 = 3'b111;
    localparam logic [2:0]  V1_G1 = 3'b101;

    // V2: K=7, generators 171/133 octal.
    localparam int unsigned V2_K  = 7;
    localparam logic [6:0]  V2_G0 = 7'b1111001;
    localparam logic [6:0]  V2_G1 = 7'b1011011;

    // XOR of the window bits selected by the generator taps.
    function automatic logic parity(input logic [MAX_K-1:0] w, input logic [MAX_K-1:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_enc_shreg.sv
// Serial-in shift register holding the encoder memory; new bits enter at the top.
module conv_enc_shreg #(
    parameter int unsigned W = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Shift right, inserting the newest bit at the MSB.
    always_comb begin
        q_d = {din, q_q[W-1:1]};
    end

    // State register with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with registered parity outputs.
module conv_encoder
    import conv_enc_pkg::*;
#(
    parameter int unsigned K  = V1_K,
    parameter logic [K-1:0] G0 = V1_G0,
    parameter logic [K-1:0] G1 = V1_G1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       in,
    output logic [1:0] parities
);

    if (K < 3 || K > MAX_K) begin : g_bad_k
        $error("conv_encoder: K=%0d outside 3..%0d", K, MAX_K);
    end
    if (G0[K-1] == 1'b0) begin : g_bad_g0
        $error("conv_encoder: G0 must tap the current input (MSB set)");
    end
    if (G1[K-1] == 1'b0) begin : g_bad_g1
        $error("conv_encoder: G1 must tap the current input (MSB set)");
    end

    logic [K-2:0] sr;
    logic [K-1:0] w;
    logic [1:0]   parities_d;
    logic [1:0]   parities_q;

    conv_enc_shreg #(
        .W (K-1)
    ) u_shreg (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (in),
        .q     (sr)
    );

    assign w = {in, sr};

    // Parity pair for the current window: [1] from G0, [0] from G1.
    always_comb begin
        parities_d    = 2'b00;
        parities_d[1] = parity(MAX_K'(w), MAX_K'(G0));
        parities_d[0] = parity(MAX_K'(w), MAX_K'(G1));
    end

    // Output register; cleared asynchronously so outputs never see in combinationally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            parities_q <= 2'b00;
        end else begin
            parities_q <= parities_d;
        end
    end

    assign parities = parities_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and random checks of conv_encoder in its V1 (K=3) and V2 (K=7) variants.
module tb_conv_encoder;
    import conv_enc_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       din = 1'b0;
    logic [1:0] par1;
    logic [1:0] par2;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state and expected outputs.
    logic [1:0] m1 = '0;
    logic [5:0] m2 = '0;
    logic [1:0] e1 = '0;
    logic [1:0] e2 = '0;

    conv_encoder #(
        .K  (V1_K),
        .G0 (V1_G0),
        .G1 (V1_G1)
    ) u_v1 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .in       (din),
        .parities (par1)
    );

    conv_encoder #(
        .K  (V2_K),
        .G0 (V2_G0),
        .G1 (V2_G1)
    ) u_v2 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .in       (din),
        .parities (par2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, advance the reference, and sample 1ns after the edge.
    task automatic step(input logic b);
        logic [2:0] w1;
        logic [6:0] w2;
        din = b;
        w1  = {b, m1};
        w2  = {b, m2};
        e1  = {^(w1 & 3'b111), ^(w1 & 3'b101)};
        e2  = {^(w2 & 7'b1111001), ^(w2 & 7'b1011011)};
        m1  = w1[2:1];
        m2  = w2[6:1];
        @(posedge CLK);
        #1;
    endtask

    // Hold reset with random input and a running clock, then release between edges.
    task automatic do_reset(input int cyc);
        RST_N = 1'b0;
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < cyc; i++) begin
            din = 1'($urandom);
            @(posedge CLK);
            #1;
            check("rst_par_v1", 32'(par1), 32'd0);
            check("rst_par_v2", 32'(par2), 32'd0);
            check("rst_sr_v1", 32'(u_v1.sr), 32'd0);
            check("rst_sr_v2", 32'(u_v2.sr), 32'd0);
        end
        #3 RST_N = 1'b1;
    endtask

    logic [1:0] v1_exp [6];
    logic [1:0] v2_exp [7];
    logic       v1_bits [6];

    initial begin
        // Window {in, sr} against the generator taps, worked by hand.
        v1_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        v1_exp  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        // Impulse response reads each generator MSB first: G0=1111001, G1=1011011.
        v2_exp  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

        #2;
        // Reset behaviour, then first encode from the zero state.
        do_reset(4);
        step(1'b1);
        check("post_rst_v1", 32'(par1), 32'd3);
        check("post_rst_v2", 32'(par2), 32'd3);

        // V1 directed sequence, then a long zero tail.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            step(v1_bits[i]);
            check($sformatf("v1_seq[%0d]", i), 32'(par1), 32'(v1_exp[i]));
        end
        check("v1_seq_final_sr", 32'(u_v1.sr), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            check($sformatf("v1_zero[%0d]", i), 32'(par1), 32'd0);
        end

        // V2 impulse and the zeros that follow it.
        do_reset(2);
        step(1'b1);
        check("v2_imp[0]", 32'(par2), 32'(v2_exp[0]));
        for (int i = 1; i < 7; i++) begin
            step(1'b0);
            check($sformatf("v2_imp[%0d]", i), 32'(par2), 32'(v2_exp[i]));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check($sformatf("v2_tail[%0d]", i), 32'(par2), 32'd0);
        end

        // Reset asserted between edges clears outputs without a clock edge.
        do_reset(2);
        step(1'b1);
        check("mid_b0", 32'(par1), 32'd3);
        step(1'b1);
        check("mid_b1", 32'(par1), 32'd1);
        #3 RST_N = 1'b0;
        m1 = '0;
        m2 = '0;
        #1;
        check("mid_async_par_v1", 32'(par1), 32'd0);
        check("mid_async_sr_v1", 32'(u_v1.sr), 32'd0);
        check("mid_async_sr_v2", 32'(u_v2.sr), 32'd0);
        #3 RST_N = 1'b1;
        step(1'b1);
        check("mid_after_v1", 32'(par1), 32'd3);

        // Random stream against the reference on both variants.
        do_reset(2);
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom));
            check("rand_v1", 32'(par1), 32'(e1));
            check("rand_v2", 32'(par2), 32'(e2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
